// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray counter and its far-side decoder.
// gray2bin is provided for checkers; the datapath only needs bin2gray.
package gray_pkg;

  localparam int GRAY_DEFAULT_WIDTH = 3;
  localparam int GRAY_MAX_WIDTH     = 64;

  // What the counter does to its binary register on a given edge.
  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_LOAD = 2'd1,
    STEP_UP   = 2'd2,
    STEP_DOWN = 2'd3
  } step_e;

  // Callers zero-extend to GRAY_MAX_WIDTH and truncate the result.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down recovers the binary value.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray encoder, one instance per counter, placed on
// the next-state binary value so the Gray output can be registered directly.
module bin_to_gray #(
  parameter int DATA_WIDTH = 3
) (
  input  logic [DATA_WIDTH-1:0] bin,
  output logic [DATA_WIDTH-1:0] gray
);

  // Each Gray bit is the XOR of adjacent binary bits; the MSB passes through.
  always_comb begin
    gray = bin ^ (bin >> 1);
  end

endmodule

// File: rtl/gray_counter.sv
// Registered binary counter with a registered Gray-coded copy, used as an
// async-FIFO pointer source. Both bin and gray come straight from flops.
// Build option: GRAY_COUNTER_UPDOWN_EN adds a dir input (0 = up, 1 = down).
module gray_counter
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
`ifdef GRAY_COUNTER_UPDOWN_EN
  input  logic                  dir,
`endif
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_bin,
  output logic [DATA_WIDTH-1:0] gray,
  output logic [DATA_WIDTH-1:0] bin,
  output logic                  wrap
);

  localparam logic [DATA_WIDTH-1:0] BIN_MAX = '1;
  localparam logic [DATA_WIDTH-1:0] BIN_ONE = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] bin_d,  bin_q;
  logic [DATA_WIDTH-1:0] gray_d, gray_q;
  logic                  wrap_d, wrap_q;
  logic                  count_down;
  step_e                 step_kind;

`ifdef GRAY_COUNTER_UPDOWN_EN
  assign count_down = dir;
`else
  assign count_down = 1'b0;
`endif

  // Classify this edge: load wins over a count step, otherwise hold.
  always_comb begin
    step_kind = STEP_HOLD;
    if (load) begin
      step_kind = STEP_LOAD;
    end else if (en) begin
      step_kind = count_down ? STEP_DOWN : STEP_UP;
    end
  end

  // Next binary value and wrap flag; wrap only marks a count rolling over,
  // never a load, so loading 0 leaves it low.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    case (step_kind)
      STEP_LOAD: begin
        bin_d = load_bin;
      end
      STEP_UP: begin
        bin_d  = bin_q + BIN_ONE;
        wrap_d = (bin_q == BIN_MAX);
      end
      STEP_DOWN: begin
        bin_d  = bin_q - BIN_ONE;
        wrap_d = (bin_q == '0);
      end
      default: begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
      end
    endcase
  end

  bin_to_gray #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bin_to_gray (
    .bin  (bin_d),
    .gray (gray_d)
  );

  // Counter, Gray copy and wrap pulse; reset clears all three immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

`ifdef FORMAL
  logic  past_valid_q;
  step_e step_q;

  // Remembers which kind of step produced the current outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      past_valid_q <= 1'b0;
      step_q       <= STEP_HOLD;
    end else begin
      past_valid_q <= 1'b1;
      step_q       <= step_kind;
    end
  end

  a_gray_enc : assert property (@(posedge clk) disable iff (!resetn)
    gray_q == DATA_WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_q))));

  a_one_bit : assert property (@(posedge clk) disable iff (!resetn)
    (past_valid_q && (step_q == STEP_UP || step_q == STEP_DOWN))
      |-> ($countones(gray_q ^ $past(gray_q)) == 1));

  c_wrap : cover property (@(posedge clk) disable iff (!resetn) wrap_q);
`endif

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;

  localparam int W = 3;
  localparam int N = 1 << W;

  typedef struct {
    int bin;
    int gray;
    bit wrap;
    bit onebit;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic [W-1:0] gray;
  logic [W-1:0] bin;
  logic         wrap;
`ifdef GRAY_COUNTER_UPDOWN_EN
  logic         dir = 1'b0;
`endif

  exp_t exp_q[$];
  int   gseq[N];
  int   m_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [W-1:0] prev_gray = '0;

  gray_counter #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
`ifdef GRAY_COUNTER_UPDOWN_EN
    .dir      (dir),
`endif
    .load     (load),
    .load_bin (load_bin),
    .gray     (gray),
    .bin      (bin),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // Reflected-binary construction: the second half of each width is the
  // first half mirrored with the new top bit set.
  initial begin
    gseq[0] = 0;
    for (int k = 0; k < W; k++) begin
      for (int i = 0; i < (1 << k); i++) begin
        gseq[(1 << k) + i] = (1 << k) | gseq[(1 << k) - 1 - i];
      end
    end
  end

  task automatic push_exp(input bit w, input bit ob);
    exp_t e;
    e.bin    = m_cnt;
    e.gray   = gseq[m_cnt];
    e.wrap   = w;
    e.onebit = ob;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; resetn is released here if it was pulled low.
  task automatic step(input bit e_i, input bit l_i, input int lb);
    bit down;
    bit w;
    @(negedge clk);
    resetn   = 1'b1;
    en       = e_i;
    load     = l_i;
    load_bin = W'(lb);
    down = 1'b0;
`ifdef GRAY_COUNTER_UPDOWN_EN
    down = dir;
`endif
    w = 1'b0;
    if (l_i) begin
      m_cnt = lb % N;
      push_exp(1'b0, 1'b0);
    end else if (e_i) begin
      if (down) begin
        w = (m_cnt == 0);
        m_cnt = (m_cnt + N - 1) % N;
      end else begin
        w = (m_cnt == N - 1);
        m_cnt = (m_cnt + 1) % N;
      end
      push_exp(w, 1'b1);
    end else begin
      push_exp(1'b0, 1'b0);
    end
  endtask

  // Pull reset low part-way through a cycle, away from any clock edge.
  task automatic reset_async();
    @(posedge clk);
    #3;
    m_cnt = 0;
    push_exp(1'b0, 1'b0);
    resetn = 1'b0;
  endtask

  // Monitor: every clock edge and every reset assertion presents a result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge resetn);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (int'(bin) != e.bin) begin
          miscompares++;
          $display("FAIL bin at %0t: got %0d expected %0d", $time, bin, e.bin);
        end
        if (int'(gray) != e.gray) begin
          miscompares++;
          $display("FAIL gray at %0t: got %b expected %b", $time, gray, W'(e.gray));
        end
        if (wrap !== e.wrap) begin
          miscompares++;
          $display("FAIL wrap at %0t: got %b expected %b", $time, wrap, e.wrap);
        end
        if (e.onebit && ($countones(gray ^ prev_gray) != 1)) begin
          miscompares++;
          $display("FAIL onebit at %0t: got %0d flips expected 1", $time,
                   $countones(gray ^ prev_gray));
        end
        prev_gray = gray;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    reset_async();

    repeat (8) step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);

    step(1'b1, 1'b1, 5);
    step(1'b1, 1'b0, 0);

    step(1'b0, 1'b1, 7);
    step(1'b0, 1'b1, 0);

    step(1'b0, 1'b1, 2);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);

    step(1'b0, 1'b1, 7);
    step(1'b1, 1'b0, 0);
    reset_async();
    step(1'b1, 1'b0, 0);

`ifdef GRAY_COUNTER_UPDOWN_EN
    reset_async();
    dir = 1'b1;
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    dir = 1'b0;
`endif

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
`ifdef GRAY_COUNTER_UPDOWN_EN
      dir = 1'($urandom_range(0, 1));
`endif
      if (r >= 98) begin
        reset_async();
      end else begin
        step(r < 70, r < 10, int'($urandom_range(0, N - 1)));
      end
    end

    step(1'b0, 1'b0, 0);
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
